// File: rtl/rob_multi_pkg.sv
// Shared types for the multi-port reorder buffer: entry status and packed entry payload.
package rob_multi_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        rob_empty = 2'd0,
        rob_wait  = 2'd1,
        rob_done  = 2'd2
    } rob_status_t;

    typedef struct packed {
        rob_status_t       status;
        logic [REG_W-1:0]  rd_addr;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   data;
        logic              mispredict;
    } rob_mentry_t;

endpackage

// File: rtl/rob_multi_if.sv
// Dispatch / CDB / lookup / commit bundle of the reorder buffer.
interface rob_multi_if #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_WB = 2
);
    import rob_multi_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                     enq_valid;
    logic                     enq_ready;
    logic [REG_W-1:0]         enq_rd_addr;
    logic [XLEN-1:0]          enq_pc;
    logic [IDX_W-1:0]         enq_idx;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*IDX_W-1:0]  wb_idx;
    logic [NUM_WB*XLEN-1:0]   wb_data;
    logic [NUM_WB-1:0]        wb_mispredict;

    logic [2*IDX_W-1:0]       rs_idx;
    logic [1:0]               rs_ready;
    logic [2*XLEN-1:0]        rs_data;

    logic                     commit_valid;
    logic                     commit_ready;
    logic [REG_W-1:0]         commit_rd_addr;
    logic [XLEN-1:0]          commit_pc;
    logic [XLEN-1:0]          commit_data;

    logic                     flush_o;
    logic [IDX_W:0]           count_o;
    logic                     empty_o;

    modport master (
        output enq_valid, enq_rd_addr, enq_pc,
        output wb_valid, wb_idx, wb_data, wb_mispredict,
        output rs_idx, commit_ready,
        input  enq_ready, enq_idx, rs_ready, rs_data,
        input  commit_valid, commit_rd_addr, commit_pc, commit_data,
        input  flush_o, count_o, empty_o
    );

    modport slave (
        input  enq_valid, enq_rd_addr, enq_pc,
        input  wb_valid, wb_idx, wb_data, wb_mispredict,
        input  rs_idx, commit_ready,
        output enq_ready, enq_idx, rs_ready, rs_data,
        output commit_valid, commit_rd_addr, commit_pc, commit_data,
        output flush_o, count_o, empty_o
    );

endinterface

// File: rtl/rob_multi_ptr.sv
// Wrap pointer with one extra MSB so equal low bits can be told apart as full vs empty.
module rob_multi_ptr #(
    parameter int unsigned PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate and retire, multi-port tag-matched write-back,
// operand lookup with same-cycle CDB forwarding, and full flush on a mispredicted commit.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_WB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rob_multi_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, tail_q;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             full, empty;
    logic             enq_fire, commit_fire, flush_now;
    logic             flush_q;

    rob_mentry_t      entry_q [DEPTH];
    rob_mentry_t      entry_d [DEPTH];
    rob_mentry_t      head_e;

    logic [IDX_W-1:0] wb_tag [NUM_WB];
    logic [XLEN-1:0]  wb_dat [NUM_WB];
    logic [IDX_W-1:0] rs_tag [2];
    logic [1:0]       rs_ready_c;
    logic [2*XLEN-1:0] rs_data_c;

    rob_multi_ptr #(.PTR_W(PTR_W)) u_head (
        .clk (clk), .rst_n (rst_n), .inc (commit_fire), .clr (flush_now), .ptr (head_q)
    );

    rob_multi_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk (clk), .rst_n (rst_n), .inc (enq_fire), .clr (flush_now), .ptr (tail_q)
    );

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign empty    = (head_q == tail_q);
    assign head_e   = entry_q[head_idx];

    assign enq_fire    = bus.enq_valid && !full;
    assign commit_fire = bus.commit_valid && bus.commit_ready;
    assign flush_now   = commit_fire && head_e.mispredict;

    assign bus.enq_ready      = !full;
    assign bus.enq_idx        = tail_idx;
    assign bus.commit_valid   = !empty && (head_e.status == rob_done);
    assign bus.commit_rd_addr = head_e.rd_addr;
    assign bus.commit_pc      = head_e.pc;
    assign bus.commit_data    = head_e.data;
    assign bus.flush_o        = flush_q;
    assign bus.count_o        = tail_q - head_q;
    assign bus.empty_o        = empty;
    assign bus.rs_ready       = rs_ready_c;
    assign bus.rs_data        = rs_data_c;

    // Unpack the flat CDB and lookup buses
    always_comb begin
        for (int p = 0; p < int'(NUM_WB); p++) begin
            wb_tag[p] = bus.wb_idx[p*IDX_W +: IDX_W];
            wb_dat[p] = bus.wb_data[p*XLEN +: XLEN];
        end
        for (int k = 0; k < 2; k++) begin
            rs_tag[k] = bus.rs_idx[k*IDX_W +: IDX_W];
        end
    end

    // Next entry state; ports scanned high to low so the lowest matching port lands last
    always_comb begin
        entry_d = entry_q;
        if (commit_fire) begin
            entry_d[head_idx].status = rob_empty;
        end
        if (enq_fire) begin
            entry_d[tail_idx] = '{status: rob_wait, rd_addr: bus.enq_rd_addr,
                                  pc: bus.enq_pc, data: '0, mispredict: 1'b0};
        end
        for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
            if (bus.wb_valid[p] && (entry_q[wb_tag[p]].status == rob_wait)) begin
                entry_d[wb_tag[p]].status     = rob_done;
                entry_d[wb_tag[p]].data       = wb_dat[p];
                entry_d[wb_tag[p]].mispredict = bus.wb_mispredict[p];
            end
        end
        if (flush_now) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_d[i].status = rob_empty;
            end
        end
    end

    // Operand lookup: stored result first, else forward from a CDB port hitting a waiting entry
    always_comb begin
        rs_ready_c = '0;
        rs_data_c  = '0;
        for (int k = 0; k < 2; k++) begin
            if (entry_q[rs_tag[k]].status == rob_done) begin
                rs_ready_c[k]               = 1'b1;
                rs_data_c[k*XLEN +: XLEN]   = entry_q[rs_tag[k]].data;
            end else if (entry_q[rs_tag[k]].status == rob_wait) begin
                for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
                    if (bus.wb_valid[p] && (wb_tag[p] == rs_tag[k])) begin
                        rs_ready_c[k]             = 1'b1;
                        rs_data_c[k*XLEN +: XLEN] = wb_dat[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            flush_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= entry_d[i];
            end
            flush_q <= flush_now;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: queue-level reference model checked every cycle plus directed scenarios.
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_WB = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int M_EMPTY = 0;
    localparam int M_WAIT  = 1;
    localparam int M_DONE  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_multi_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) bus ();
    rob_multi #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue of tags plus per-tag state
    int          m_st   [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_pc   [DEPTH];
    logic [31:0] m_data [DEPTH];
    bit          m_mis  [DEPTH];
    int          m_q[$];
    int          m_next = 0;
    bit          m_flush = 1'b0;
    bit          started = 1'b0;
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];

    always @(posedge clk) begin : model
        bit cf, ef, fl;
        int t, h;
        started = 1'b1;
        if (!rst_n) begin
            m_q.delete();
            foreach (m_st[i]) m_st[i] = M_EMPTY;
            m_next  = 0;
            m_flush = 1'b0;
        end else begin
            cf = (m_q.size() > 0) && (m_st[m_q[0]] == M_DONE) && bus.commit_ready;
            ef = bus.enq_valid && (m_q.size() < int'(DEPTH));
            fl = 1'b0;
            for (int p = 0; p < int'(NUM_WB); p++) begin
                t = int'(bus.wb_idx[p*IDX_W +: IDX_W]);
                if (bus.wb_valid[p] && m_st[t] == M_WAIT) begin
                    m_st[t]   = M_DONE;
                    m_data[t] = bus.wb_data[p*32 +: 32];
                    m_mis[t]  = bus.wb_mispredict[p];
                end
            end
            if (cf) begin
                h = m_q.pop_front();
                m_st[h] = M_EMPTY;
                fl = m_mis[h];
            end
            if (fl) begin
                m_q.delete();
                foreach (m_st[i]) m_st[i] = M_EMPTY;
                m_next = 0;
            end else if (ef) begin
                m_st[m_next]   = M_WAIT;
                m_rd[m_next]   = bus.enq_rd_addr;
                m_pc[m_next]   = bus.enq_pc;
                m_data[m_next] = '0;
                m_mis[m_next]  = 1'b0;
                m_q.push_back(m_next);
                m_next = (m_next + 1) % int'(DEPTH);
            end
            m_flush = fl;
        end
    end

    always @(negedge clk) begin : compare
        int n, t;
        bit cv, er, found;
        logic [31:0] ed;
        if (started) begin
            n  = m_q.size();
            cv = (n > 0) && (m_st[m_q[0]] == M_DONE);
            chk("enq_ready", bus.enq_ready, n < int'(DEPTH));
            chk("enq_idx", bus.enq_idx, m_next);
            chk("commit_valid", bus.commit_valid, cv);
            if (cv) begin
                chk("commit_rd_addr", bus.commit_rd_addr, m_rd[m_q[0]]);
                chk("commit_pc", bus.commit_pc, m_pc[m_q[0]]);
                chk("commit_data", bus.commit_data, m_data[m_q[0]]);
            end
            chk("flush_o", bus.flush_o, m_flush);
            chk("count_o", bus.count_o, n);
            chk("empty_o", bus.empty_o, n == 0);
            for (int k = 0; k < 2; k++) begin
                t = int'(bus.rs_idx[k*IDX_W +: IDX_W]);
                er = 1'b0; ed = '0; found = 1'b0;
                if (m_st[t] == M_DONE) begin
                    er = 1'b1; ed = m_data[t];
                end else if (m_st[t] == M_WAIT) begin
                    for (int p = 0; p < int'(NUM_WB); p++) begin
                        if (!found && bus.wb_valid[p] && int'(bus.wb_idx[p*IDX_W +: IDX_W]) == t) begin
                            found = 1'b1; er = 1'b1; ed = bus.wb_data[p*32 +: 32];
                        end
                    end
                end
                chk("rs_ready", bus.rs_ready[k], er);
                chk("rs_data", bus.rs_data[k*32 +: 32], ed);
            end
            if (rst_n && bus.commit_valid && bus.commit_ready) begin
                log_pc.push_back(bus.commit_pc);
                log_data.push_back(bus.commit_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.enq_valid = 1'b0; bus.enq_rd_addr = '0; bus.enq_pc = '0;
        bus.wb_valid = '0; bus.wb_idx = '0; bus.wb_data = '0; bus.wb_mispredict = '0;
        bus.rs_idx = '0; bus.commit_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [4:0] rd);
        bus.enq_valid = 1'b1; bus.enq_pc = pc; bus.enq_rd_addr = rd;
        step();
        bus.enq_valid = 1'b0;
    endtask

    task automatic wb1(input int port, input int tag, input logic [31:0] data, input bit mis);
        bus.wb_valid[port] = 1'b1;
        bus.wb_idx[port*IDX_W +: IDX_W] = IDX_W'(tag);
        bus.wb_data[port*32 +: 32] = data;
        bus.wb_mispredict[port] = mis;
        step();
        bus.wb_valid = '0; bus.wb_mispredict = '0;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_enq_ready"}, bus.enq_ready, 1);
        chk({tagname, "_enq_idx"}, bus.enq_idx, 0);
        chk({tagname, "_commit_valid"}, bus.commit_valid, 0);
        chk({tagname, "_flush_o"}, bus.flush_o, 0);
        chk({tagname, "_count_o"}, bus.count_o, 0);
        chk({tagname, "_empty_o"}, bus.empty_o, 1);
        chk({tagname, "_rs_ready"}, bus.rs_ready, 0);
    endtask

    function automatic logic [31:0] log_at(input int i, input bit want_pc);
        if (i >= (want_pc ? log_pc.size() : log_data.size())) return 32'hFFFF_FFFF;
        return want_pc ? log_pc[i] : log_data[i];
    endfunction

    initial begin : stim
        bit hit;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_dt [3];
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
        exp_dt[0] = 32'hB;   exp_dt[1] = 32'hC;   exp_dt[2] = 32'hA;

        // Out-of-order write-back, in-order commit
        clear_inputs();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst0");
        log_pc.delete(); log_data.delete();
        bus.commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) enq(32'h100 + 32'(4*i), 5'(i + 1));
        wb1(0, 2, 32'hA, 1'b0);
        wb1(0, 0, 32'hB, 1'b0);
        wb1(0, 1, 32'hC, 1'b0);
        repeat (4) step();
        @(negedge clk);
        chk("s1_commits", log_pc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("s1_pc", log_at(i, 1'b1), exp_pc[i]);
            chk("s1_data", log_at(i, 1'b0), exp_dt[i]);
        end
        chk("s1_empty", bus.empty_o, 1);

        // Fill to full, ignored extra enqueue, commit while full, wrap of the tail
        do_reset();
        for (int i = 0; i < 32; i++) enq(32'h200 + 32'(4*i), 5'd1);
        @(negedge clk);
        chk("s2_full_ready", bus.enq_ready, 0);
        chk("s2_full_count", bus.count_o, 32);
        enq(32'hDEAD, 5'd9);
        @(negedge clk);
        chk("s2_33rd_count", bus.count_o, 32);
        chk("s2_33rd_head_pc", bus.commit_pc, 32'h200);
        wb1(0, 0, 32'h77, 1'b0);
        bus.commit_ready = 1'b1;
        @(negedge clk);
        chk("s2_cv", bus.commit_valid, 1);
        chk("s2_full_commit_ready", bus.enq_ready, 0);
        step();
        bus.commit_ready = 1'b0;
        @(negedge clk);
        chk("s2_space_ready", bus.enq_ready, 1);
        chk("s2_wrap_idx", bus.enq_idx, 0);
        chk("s2_count31", bus.count_o, 31);
        enq(32'h300, 5'd3);

        // Two ports on the same tag: lowest port wins, forwarded and stored
        bus.wb_valid = 2'b11;
        bus.wb_idx = {5'd5, 5'd5};
        bus.wb_data = {32'h22, 32'h11};
        bus.rs_idx = {5'd6, 5'd5};
        @(negedge clk);
        chk("s3_fwd_ready", bus.rs_ready, 2'b01);
        chk("s3_fwd_data", bus.rs_data[31:0], 32'h11);
        step();
        bus.wb_valid = '0;
        @(negedge clk);
        chk("s3_stored_ready", bus.rs_ready, 2'b01);
        chk("s3_stored_data", bus.rs_data[31:0], 32'h11);

        // Mispredicted commit flushes; the enqueue in the commit cycle is dropped
        do_reset();
        for (int i = 0; i < 5; i++) enq(32'h200 + 32'(4*i), 5'(i + 2));
        bus.wb_valid = 2'b11;
        bus.wb_idx = {5'd1, 5'd0};
        bus.wb_data = {32'h51, 32'h50};
        bus.wb_mispredict = 2'b10;
        step();
        bus.wb_valid = '0; bus.wb_mispredict = '0;
        bus.commit_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (bus.commit_valid && bus.commit_pc == 32'h204) hit = 1'b1;
        end
        chk("s4_reach_tag1", hit, 1);
        #1;
        bus.enq_valid = 1'b1; bus.enq_pc = 32'h300; bus.enq_rd_addr = 5'd7;
        step();
        bus.enq_valid = 1'b0;
        bus.commit_ready = 1'b0;
        @(negedge clk);
        chk("s4_flush", bus.flush_o, 1);
        chk("s4_count", bus.count_o, 0);
        chk("s4_empty", bus.empty_o, 1);
        chk("s4_idx", bus.enq_idx, 0);
        step();
        @(negedge clk);
        chk("s4_flush_pulse", bus.flush_o, 0);
        enq(32'h400, 5'd2);
        @(negedge clk);
        chk("s4_reenq_count", bus.count_o, 1);

        // Steady state: enqueue and commit together at occupancy 4
        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4*i), 5'd1);
        bus.wb_valid = 2'b11; bus.wb_idx = {5'd1, 5'd0}; bus.wb_data = {32'h1001, 32'h1000};
        step();
        bus.wb_idx = {5'd3, 5'd2}; bus.wb_data = {32'h1003, 32'h1002};
        step();
        bus.wb_valid = '0;
        log_pc.delete(); log_data.delete();
        for (int i = 0; i < 10; i++) begin
            bus.enq_valid = 1'b1; bus.enq_pc = 32'h510 + 32'(4*i); bus.enq_rd_addr = 5'd1;
            bus.commit_ready = 1'b1;
            bus.wb_valid = (i >= 1) ? 2'b01 : 2'b00;
            bus.wb_idx[4:0] = 5'(3 + i);
            bus.wb_data[31:0] = 32'h1000 + 32'(3 + i);
            @(negedge clk);
            chk("s5_count", bus.count_o, 4);
            chk("s5_cv", bus.commit_valid, 1);
            step();
        end
        clear_inputs();
        @(negedge clk);
        chk("s5_commits", log_pc.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("s5_pc", log_at(i, 1'b1), 32'h500 + 32'(4*i));
            chk("s5_data", log_at(i, 1'b0), 32'h1000 + 32'(i));
        end

        // Reset mid-operation with a mispredicted entry ready at head
        do_reset();
        for (int i = 0; i < 6; i++) enq(32'h600 + 32'(4*i), 5'd4);
        wb1(0, 0, 32'h99, 1'b1);
        @(negedge clk);
        chk("s6_count6", bus.count_o, 6);
        #1;
        rst_n = 1'b0;
        bus.commit_ready = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("s6_no_flush", bus.flush_o, 0);
            chk("s6_no_commit", bus.commit_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
